// File: rtl/cdb_arbiter_pkg.sv
// Shared constants, types and index helper for the CDB arbiter.
// Unit numbering matches the functional-unit order of the core.
package cdb_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 32;

    localparam int FU_ALU = 0;
    localparam int FU_MDF = 1;
    localparam int FU_LS  = 2;
    localparam int FU_BR  = 3;

    localparam int CDB_SRC_W =
        (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [NUM_REQ-1:0]   req_vec_t;
    typedef logic [CDB_SRC_W-1:0] src_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [DATA_W-1:0]    data_t;

    // Modulo-NUM_REQ addition of two unit indices
    function automatic src_t idx_add(src_t a, src_t b);
        logic [CDB_SRC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (CDB_SRC_W+1)'(NUM_REQ))
            s = s - (CDB_SRC_W+1)'(NUM_REQ);
        return s[CDB_SRC_W-1:0];
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between the functional units and the arbiter.
// master = requesting side, slave = arbiter.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic                      flush;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*TAG_W-1:0]  reqTag;
    logic [NUM_REQ*DATA_W-1:0] reqData;
    logic [NUM_REQ-1:0]        grant;
    logic                      cdbValid;
    logic [TAG_W-1:0]          cdbTag;
    logic [DATA_W-1:0]         cdbData;
    logic [CDB_SRC_W-1:0]      cdbSrc;

    modport master (
        output flush, req, reqTag, reqData,
        input  grant, cdbValid, cdbTag, cdbData, cdbSrc
    );

    modport slave (
        input  flush, req, reqTag, reqData,
        output grant, cdbValid, cdbTag, cdbData, cdbSrc
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin winner search: rotate so ptr sits at bit 0,
// take the lowest set bit, then map back to a unit index.
module cdb_arbiter_rr_pick
    import cdb_arbiter_pkg::*;
(
    input  req_vec_t eff_i,
    input  src_t     ptr_i,
    output src_t     win_o,
    output logic     found_o
);

    req_vec_t rot;
    src_t     idx;

    // Rotate the request vector so that unit ptr lands at bit 0
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rot[i] = eff_i[idx_add(src_t'(i), ptr_i)];
    end

    // Fixed-priority encoder, lowest index wins
    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i])
                idx = src_t'(i);
    end

    assign win_o   = idx_add(idx, ptr_i);
    assign found_o = |eff_i;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one round-robin winner per cycle,
// registered broadcast and a one-cycle grant back to the winner.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        nRST,
    cdb_arbiter_if.slave cdb
);

    req_vec_t grant_q, grant_d;
    logic     valid_q, valid_d;
    tag_t     tag_q,   tag_d;
    data_t    data_q,  data_d;
    src_t     src_q,   src_d;
    src_t     ptr_q,   ptr_d;

    req_vec_t eff;
    src_t     win;
    logic     found;

    // A unit granted this cycle is masked so it cannot win twice
    assign eff = cdb.req & ~grant_q;

    cdb_arbiter_rr_pick u_pick (
        .eff_i   (eff),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .found_o (found)
    );

    // Next broadcast: winner's payload, or idle with payload held
    always_comb begin
        grant_d = '0;
        valid_d = 1'b0;
        tag_d   = tag_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (!cdb.flush && found) begin
            grant_d = req_vec_t'(1) << win;
            valid_d = 1'b1;
            tag_d   = cdb.reqTag[int'(win)*TAG_W +: TAG_W];
            data_d  = cdb.reqData[int'(win)*DATA_W +: DATA_W];
            src_d   = win;
            ptr_d   = idx_add(win, src_t'(1));
        end
    end

    // Broadcast and pointer registers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            grant_q <= grant_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign cdb.grant    = grant_q;
    assign cdb.cdbValid = valid_q;
    assign cdb.cdbTag   = tag_q;
    assign cdb.cdbData  = data_q;
    assign cdb.cdbSrc   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus
// random requesters, checked against a behavioural model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk;
    logic nRST;

    cdb_arbiter_if bus();

    cdb_arbiter dut (
        .clk  (clk),
        .nRST (nRST),
        .cdb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int       m_ptr;
    req_vec_t m_grant;
    logic     m_valid;
    tag_t     m_tag;
    data_t    m_data;
    int       m_src;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_grant"}, 64'(bus.grant), 64'(m_grant));
        check({tag, "_valid"}, 64'(bus.cdbValid), 64'(m_valid));
        check({tag, "_tag"}, 64'(bus.cdbTag), 64'(m_tag));
        check({tag, "_data"}, 64'(bus.cdbData), 64'(m_data));
        check({tag, "_src"}, 64'(bus.cdbSrc), 64'(m_src));
    endtask

    task automatic set_unit(input int i, input tag_t t,
                            input data_t d);
        bus.reqTag[i*TAG_W +: TAG_W]    = t;
        bus.reqData[i*DATA_W +: DATA_W] = d;
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must drop at once
    task automatic do_reset(input string tag);
        nRST = 1'b0;
        #1;
        m_ptr   = 0;
        m_grant = '0;
        m_valid = 1'b0;
        m_tag   = '0;
        m_data  = '0;
        m_src   = 0;
        check_all(tag);
        #1;
        nRST = 1'b1;
    endtask

    // One clock edge: predict from the inputs presented, then compare
    task automatic tick(input string tag);
        req_vec_t eff;
        int       w;
        tag_t     wt;
        data_t    wd;
        eff = bus.req & ~m_grant;
        w   = -1;
        if (!bus.flush)
            for (int k = 0; k < NUM_REQ; k++)
                if (w < 0 && eff[(m_ptr + k) % NUM_REQ])
                    w = (m_ptr + k) % NUM_REQ;
        if (w >= 0) begin
            wt = bus.reqTag[w*TAG_W +: TAG_W];
            wd = bus.reqData[w*DATA_W +: DATA_W];
        end else begin
            wt = '0;
            wd = '0;
        end
        @(posedge clk);
        if (w >= 0) begin
            m_grant = req_vec_t'(1) << w;
            m_valid = 1'b1;
            m_tag   = wt;
            m_data  = wd;
            m_src   = w;
            m_ptr   = (w + 1) % NUM_REQ;
        end else begin
            m_grant = '0;
            m_valid = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        int cnt [NUM_REQ];
        int nb;
        int at_grant;
        int hits;

        nRST        = 1'b0;
        bus.flush   = 1'b0;
        bus.req     = '0;
        bus.reqTag  = '0;
        bus.reqData = '0;
        #2;
        do_reset("rst");
        tick("idle");

        // 1: single request, then masked cycle
        bus.req = 4'b0001;
        set_unit(FU_ALU, 4'd3, 32'd5);
        tick("t1a");
        check("t1_grant", 64'(bus.grant), 64'h1);
        check("t1_tag", 64'(bus.cdbTag), 64'd3);
        check("t1_data", 64'(bus.cdbData), 64'd5);
        tick("t1b");
        check("t1_gap", 64'(bus.cdbValid), 64'd0);
        bus.req = '0;
        tick("t1c");

        // 2: all request, strict rotation, no gaps
        do_reset("t2rst");
        bus.req = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_unit(i, tag_t'(i + 1), data_t'(32'h50 + i));
            cnt[i] = 0;
        end
        for (int k = 0; k < 8; k++) begin
            tick("t2");
            check("t2_seq", 64'(bus.grant), 64'd1 << (k % 4));
            check("t2_nogap", 64'(bus.cdbValid), 64'd1);
            cnt[bus.cdbSrc]++;
        end
        for (int i = 0; i < NUM_REQ; i++)
            check("t2_fair", 64'(cnt[i]), 64'd2);
        bus.req = '0;
        tick("t2end");

        // 3: wrap-around from ptr=2
        do_reset("t3rst");
        bus.req = 4'b0010;
        tick("t3a");
        check("t3_g1", 64'(bus.grant), 64'h2);
        bus.req = 4'b0011;
        tick("t3b");
        check("t3_wrap", 64'(bus.grant), 64'h1);
        bus.req = '0;
        tick("t3c");
        bus.req = 4'b0011;
        tick("t3d");
        check("t3_ptr1", 64'(bus.grant), 64'h2);
        bus.req = '0;
        tick("t3e");

        // 4: flush suppresses one arbitration
        bus.req   = 4'b0100;
        bus.flush = 1'b1;
        tick("t4a");
        check("t4_flush", 64'(bus.cdbValid), 64'd0);
        bus.flush = 1'b0;
        tick("t4b");
        check("t4_grant", 64'(bus.grant), 64'h4);
        bus.req = '0;
        tick("t4c");

        // 5: reset mid-broadcast
        bus.req = 4'b1000;
        set_unit(FU_BR, 4'd7, 32'hCAFE0007);
        tick("t5a");
        check("t5_valid", 64'(bus.cdbValid), 64'd1);
        do_reset("t5rst");
        tick("t5b");
        check("t5_grant", 64'(bus.grant), 64'h8);
        bus.req = '0;
        tick("t5c");

        // 6: MDF holds a result while ALU requests every other cycle
        do_reset("t6rst");
        set_unit(FU_MDF, 4'd9, 32'hABCD1234);
        bus.req[FU_MDF] = 1'b1;
        nb       = 0;
        at_grant = -1;
        hits     = 0;
        for (int c = 0; c < 10; c++) begin
            bus.req[FU_ALU] = (c % 2 == 0);
            set_unit(FU_ALU, tag_t'(c), data_t'(32'h100 + c));
            tick("t6");
            if (bus.cdbValid) nb++;
            if (bus.cdbValid && bus.cdbData == 32'hABCD1234)
                hits++;
            if (bus.grant[FU_MDF]) begin
                if (at_grant < 0) at_grant = nb;
                bus.req[FU_MDF] = 1'b0;
            end
        end
        check("t6_seen", 64'(at_grant > 0), 64'd1);
        check("t6_lat", 64'(at_grant <= 2), 64'd1);
        check("t6_once", 64'(hits), 64'd1);
        bus.req = '0;
        tick("t6end");

        // Random requesters obeying the handshake, random flush
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.grant[i]) begin
                    if ($urandom_range(1, 0) == 0)
                        bus.req[i] = 1'b0;
                    else
                        set_unit(i, tag_t'($urandom), data_t'($urandom));
                end else if (!bus.req[i] && $urandom_range(2, 0) == 0) begin
                    bus.req[i] = 1'b1;
                    set_unit(i, tag_t'($urandom), data_t'($urandom));
                end
            end
            bus.flush = ($urandom_range(7, 0) == 0);
            tick("rnd");
            check("rnd_cons", 64'(bus.cdbValid), 64'(|bus.grant));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
